// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file: round-robin between ALU and load unit,
// one registered write per cycle, XZR writes dropped, plus a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              flush,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_wrAddr,
  output logic [DATA_W-1:0] rf_wrData,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic              busyA,
  output logic              busyB,
  output logic [31:0]       busy_vec
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_t;

  localparam logic [ADDR_W-1:0] XZR = '1;

  src_t        last;
  logic        grantAlu;
  logic        grantMem;
  logic [31:0] busyNext;

  // On a conflict the source that did not win last time gets the port.
  always_comb begin
    grantAlu = 1'b0;
    grantMem = 1'b0;
    if (!reset) begin
      if (alu_valid && mem_valid) begin
        grantAlu = (last == SRC_MEM);
        grantMem = (last == SRC_ALU);
      end else begin
        grantAlu = alu_valid;
        grantMem = mem_valid;
      end
    end
  end

  assign alu_ready = grantAlu;
  assign mem_ready = grantMem;

  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= SRC_MEM;
      rf_write  <= 1'b0;
      rf_wrAddr <= '0;
      rf_wrData <= '0;
    end else if (grantAlu) begin
      last      <= SRC_ALU;
      rf_write  <= (alu_addr != XZR);
      rf_wrAddr <= alu_addr;
      rf_wrData <= alu_data;
    end else if (grantMem) begin
      last      <= SRC_MEM;
      rf_write  <= (mem_addr != XZR);
      rf_wrAddr <= mem_addr;
      rf_wrData <= mem_data;
    end else begin
      rf_write  <= 1'b0;
    end
  end

  // Set is applied after clear so a new producer keeps the register pending.
  always_comb begin
    busyNext = flush ? 32'd0 : busy_vec;
    if (rf_write) busyNext[rf_wrAddr] = 1'b0;
    if (issue_valid && issue_addr != XZR) busyNext[issue_addr] = 1'b1;
    busyNext[31] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_vec <= '0;
    else       busy_vec <= busyNext;
  end

  assign busyA = busy_vec[rdAddrA];
  assign busyB = busy_vec[rdAddrB];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level model of grants, writes and pending registers.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr = '0, mem_addr = '0, issue_addr = '0;
  logic [63:0] alu_data = '0, mem_data = '0;
  logic        issue_valid = 1'b0, flush = 1'b0;
  logic        rf_write;
  logic [4:0]  rf_wrAddr;
  logic [63:0] rf_wrData;
  logic [4:0]  rdAddrA = '0, rdAddrB = '0;
  logic        busyA, busyB;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [31:0] mBusy = '0;
  bit        mAluWonLast = 1'b0;
  bit        mWrite = 1'b0;
  bit [4:0]  mAddr = '0;
  bit [63:0] mData = '0;

  regfile_wb_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .flush(flush),
    .rf_write(rf_write), .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData),
    .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .busyA(busyA), .busyB(busyB), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic modelGrant(output bit ga, output bit gm);
    ga = 1'b0;
    gm = 1'b0;
    if (!reset) begin
      if (alu_valid && mem_valid) begin
        ga = !mAluWonLast;
        gm = mAluWonLast;
      end else begin
        ga = alu_valid;
        gm = mem_valid;
      end
    end
  endtask

  // Advance one clock: compute model next state from the stable inputs, then land 1ns after the edge.
  task automatic tick();
    bit ga, gm;
    bit [31:0] nb;
    modelGrant(ga, gm);
    if (reset) begin
      nb = '0; mAluWonLast = 1'b0; mWrite = 1'b0; mAddr = '0; mData = '0;
    end else begin
      nb = flush ? 32'd0 : mBusy;
      if (mWrite) nb[mAddr] = 1'b0;
      if (issue_valid && issue_addr != 5'd31) nb[issue_addr] = 1'b1;
      if (ga) begin
        mWrite = (alu_addr != 5'd31); mAddr = alu_addr; mData = alu_data; mAluWonLast = 1'b1;
      end else if (gm) begin
        mWrite = (mem_addr != 5'd31); mAddr = mem_addr; mData = mem_data; mAluWonLast = 1'b0;
      end else begin
        mWrite = 1'b0;
      end
    end
    @(posedge clk);
    mBusy = nb;
    #1;
  endtask

  task automatic idleInputs();
    alu_valid = 0; mem_valid = 0; issue_valid = 0; flush = 0;
  endtask

  task automatic doReset();
    reset = 1; idleInputs(); tick(); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; alu_valid = 1; alu_addr = 5'd4; issue_valid = 1; issue_addr = 5'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
        errors++; $display("FAIL reset_ready cyc%0d: alu_ready=%b mem_ready=%b, required 0/0", i, alu_ready, mem_ready);
      end
      tick();
      checks++;
      if (rf_write !== 1'b0 || busy_vec !== 32'd0) begin
        errors++; $display("FAIL reset_state cyc%0d: rf_write=%b busy_vec=%h, required 0/00000000", i, rf_write, busy_vec);
      end
    end
    reset = 0; idleInputs();
    tick();
    checks++;
    if (rf_write !== 1'b0 || busy_vec !== 32'd0 || rf_wrAddr !== 5'd0 || rf_wrData !== 64'd0) begin
      errors++; $display("FAIL reset_after: rf_write=%b busy_vec=%h addr=%0d data=%h, required all zero", rf_write, busy_vec, rf_wrAddr, rf_wrData);
    end
  endtask

  task automatic test_single();
    issue_valid = 1; issue_addr = 5'd3; rdAddrA = 5'd3;
    tick(); issue_valid = 0; #1;
    checks++;
    if (busyA !== 1'b1) begin errors++; $display("FAIL single_busy_set: busyA=%b, required 1", busyA); end
    tick();
    alu_valid = 1; alu_addr = 5'd3; alu_data = 64'hDEAD_BEEF_0000_0001; #1;
    checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      errors++; $display("FAIL single_grant: alu_ready=%b mem_ready=%b, required 1/0", alu_ready, mem_ready);
    end
    tick(); alu_valid = 0;
    checks++;
    if (rf_write !== 1'b1 || rf_wrAddr !== 5'd3 || rf_wrData !== 64'hDEAD_BEEF_0000_0001 || busyA !== 1'b1) begin
      errors++; $display("FAIL single_write: rf_write=%b addr=%0d data=%h busyA=%b, required 1/3/deadbeef00000001/1", rf_write, rf_wrAddr, rf_wrData, busyA);
    end
    tick();
    checks++;
    if (busyA !== 1'b0 || rf_write !== 1'b0) begin
      errors++; $display("FAIL single_clear: busyA=%b rf_write=%b, required 0/0", busyA, rf_write);
    end
  endtask

  task automatic test_conflict();
    bit [4:0] expAddr [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
    doReset();
    alu_valid = 1; mem_valid = 1; alu_addr = 5'd1; mem_addr = 5'd2;
    for (int i = 0; i < 4; i++) begin
      alu_data = 64'h100 + 64'(i); mem_data = 64'h200 + 64'(i); #1;
      checks++;
      if (alu_ready !== (expAddr[i] == 5'd1) || mem_ready !== (expAddr[i] == 5'd2)) begin
        errors++; $display("FAIL conflict_grant%0d: alu_ready=%b mem_ready=%b, required %b/%b", i, alu_ready, mem_ready, expAddr[i] == 5'd1, expAddr[i] == 5'd2);
      end
      tick();
      checks++;
      if (rf_write !== 1'b1 || rf_wrAddr !== expAddr[i] || rf_wrData !== ((expAddr[i] == 5'd1) ? 64'h100 : 64'h200) + 64'(i)) begin
        errors++; $display("FAIL conflict_write%0d: rf_write=%b addr=%0d data=%h, required 1/%0d", i, rf_write, rf_wrAddr, rf_wrData, expAddr[i]);
      end
    end
    idleInputs();
  endtask

  task automatic test_xzr();
    mem_valid = 1; mem_addr = 5'd31; mem_data = '1; #1;
    checks++;
    if (mem_ready !== 1'b1) begin errors++; $display("FAIL xzr_ready: mem_ready=%b, required 1", mem_ready); end
    tick(); mem_valid = 0;
    checks++;
    if (rf_write !== 1'b0) begin errors++; $display("FAIL xzr_write: rf_write=%b, required 0", rf_write); end
    issue_valid = 1; issue_addr = 5'd31; rdAddrB = 5'd31;
    tick(); issue_valid = 0;
    checks++;
    if (busy_vec[31] !== 1'b0 || busyB !== 1'b0) begin
      errors++; $display("FAIL xzr_busy: busy_vec[31]=%b busyB=%b, required 0/0", busy_vec[31], busyB);
    end
  endtask

  task automatic test_setclear_flush();
    doReset();
    alu_valid = 1; alu_addr = 5'd7; alu_data = 64'h77;
    tick(); alu_valid = 0;
    issue_valid = 1; issue_addr = 5'd7;
    checks++;
    if (rf_write !== 1'b1 || rf_wrAddr !== 5'd7) begin
      errors++; $display("FAIL setclr_write: rf_write=%b addr=%0d, required 1/7", rf_write, rf_wrAddr);
    end
    tick(); issue_valid = 0;
    checks++;
    if (busy_vec[7] !== 1'b1) begin errors++; $display("FAIL setclr_busy7: busy_vec[7]=%b, required 1", busy_vec[7]); end
    doReset();
    for (int a = 4; a < 8; a++) begin
      issue_valid = 1; issue_addr = 5'(a); tick();
    end
    issue_valid = 0;
    checks++;
    if (busy_vec !== 32'h0000_00F0) begin errors++; $display("FAIL flush_setup: busy_vec=%h, required 000000f0", busy_vec); end
    alu_valid = 1; alu_addr = 5'd9; alu_data = 64'h99; flush = 1;
    tick(); alu_valid = 0; flush = 0;
    checks++;
    if (busy_vec !== 32'd0 || rf_write !== 1'b1 || rf_wrAddr !== 5'd9 || rf_wrData !== 64'h99) begin
      errors++; $display("FAIL flush_pending: busy_vec=%h rf_write=%b addr=%0d data=%h, required 0/1/9/99", busy_vec, rf_write, rf_wrAddr, rf_wrData);
    end
    issue_valid = 1; issue_addr = 5'd12; flush = 1;
    tick(); issue_valid = 0; flush = 0;
    checks++;
    if (busy_vec !== 32'h0000_1000) begin errors++; $display("FAIL flush_issue: busy_vec=%h, required 00001000", busy_vec); end
  endtask

  task automatic test_random();
    bit ga, gm, prevGa, prevGm;
    int aluWait, memWait;
    prevGa = 0; prevGm = 0; aluWait = 0; memWait = 0;
    for (int c = 0; c < 400; c++) begin
      if (!alu_valid || prevGa) begin
        alu_valid = ($urandom_range(0, 3) != 0); alu_addr = 5'($urandom_range(0, 31)); alu_data = {$urandom, $urandom};
      end
      if (!mem_valid || prevGm) begin
        mem_valid = ($urandom_range(0, 3) != 0); mem_addr = 5'($urandom_range(0, 31)); mem_data = {$urandom, $urandom};
      end
      issue_valid = $urandom_range(0, 1); issue_addr = 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 15) == 0);
      rdAddrA = 5'($urandom_range(0, 31)); rdAddrB = 5'($urandom_range(0, 31));
      #1;
      modelGrant(ga, gm);
      checks++;
      if (alu_ready !== ga || mem_ready !== gm || busyA !== mBusy[rdAddrA] || busyB !== mBusy[rdAddrB]) begin
        errors++; $display("FAIL rand_comb c%0d: ready=%b%b busy=%b%b, required %b%b %b%b", c, alu_ready, mem_ready, busyA, busyB, ga, gm, mBusy[rdAddrA], mBusy[rdAddrB]);
      end
      aluWait = (alu_valid && !alu_ready) ? aluWait + 1 : 0;
      memWait = (mem_valid && !mem_ready) ? memWait + 1 : 0;
      checks++;
      if (aluWait > 1 || memWait > 1) begin
        errors++; $display("FAIL rand_stall c%0d: waits alu=%0d mem=%0d, required <=1", c, aluWait, memWait);
      end
      tick();
      prevGa = ga; prevGm = gm;
      checks++;
      if (rf_write !== mWrite || busy_vec !== mBusy || (mWrite && (rf_wrAddr !== mAddr || rf_wrData !== mData))) begin
        errors++; $display("FAIL rand_reg c%0d: wr=%b addr=%0d data=%h busy=%h, required %b/%0d/%h/%h", c, rf_write, rf_wrAddr, rf_wrData, busy_vec, mWrite, mAddr, mData, mBusy);
      end
    end
    idleInputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_xzr();
    test_setclear_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
